pe_ctrl_sequencer: RTL and testbench
====================================

Name: pe_ctrl_sequencer

Overview:
Per-PE control sequencer. Generates the packed PE control word each cycle for one output tile: accumulation beats, optional partial-sum read-back, then flush/write-back of each output to the PE buffer. Sits between the layer scheduler (start/config) and a PE column (ctrl bus). Outputs are fully registered.

Parameters:
PE_BUF_ADDR_WIDTH, 10, PE buffer address width
OP_CODE_WIDTH, 3, PE op-code width (fixed 3 in the ctrl packing)
CNT_WIDTH, 16, accumulation-length counter width
CTRL_WIDTH (localparam), 8+2*PE_BUF_ADDR_WIDTH, packed ctrl width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a tile; sampled only in IDLE
cfg_acc_len  input  CNT_WIDTH  valid beats accumulated per output
cfg_num_out  input  PE_BUF_ADDR_WIDTH  outputs in the tile
cfg_op_code  input  3  op code driven during accumulation
cfg_accumulate  input  1  1 = read prior partial sum from the PE buffer at the first beat of each output
data_valid  input  1  operand beat valid this cycle
ctrl  output  CTRL_WIDTH  {buf_rd_addr, buf_wr_addr, flush, write_valid, pe_buffer_write_req, pe_buffer_read_req, enable, op_code}, MSB first
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at tile end

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ctrl, busy, done, and all counters = 0. Reset asserted mid-tile aborts immediately. No flush is issued.
- Config (start, cfg_acc_len, cfg_num_out, cfg_op_code, cfg_accumulate) is latched on the clock edge where state=IDLE and start=1. Later cfg changes have no effect until the next accepted start.
- start while busy=1 is ignored.
- States: IDLE, ACCUM, FLUSH, DONE.
- IDLE:
  - start=1 with latched cfg_acc_len==0 or cfg_num_out==0 -> DONE.
  - start=1 otherwise -> ACCUM; acc_cnt=0, out_idx=0.
  - ctrl=0.
- ACCUM, data_valid=1, registered into ctrl next cycle:
  - enable=1, op_code=cfg_op_code; acc_cnt++.
  - If acc_cnt==0 and cfg_accumulate=1: also pe_buffer_read_req=1, buf_rd_addr=out_idx.
  - If acc_cnt==cfg_acc_len-1: acc_cnt returns to 0 and state -> FLUSH.
- ACCUM, data_valid=0: enable=0, read_req=0, op_code=cfg_op_code; counters hold. Stall of any length is allowed.
- FLUSH (exactly one cycle): ctrl has flush=1, write_valid=1, pe_buffer_write_req=1, buf_wr_addr=out_idx, enable=0.
  - out_idx==cfg_num_out-1 -> DONE.
  - Otherwise out_idx++ and -> ACCUM.
  - data_valid in FLUSH is ignored; the upstream producer must not present a beat then.
- DONE (one cycle): done=1, ctrl=0, busy=1 -> IDLE. start in the DONE cycle is ignored.
- Latency:
  - data_valid to ctrl.enable = 1 cycle.
  - Last accumulation beat to flush = 2 cycles: enable in cycle N+1, flush/write in N+2.
- Bit fields not named for a state are 0. buf_rd_addr and buf_wr_addr are 0 when their request bit is 0.
- cfg_acc_len==1: every beat is both first and last. read_req (if enabled) and the transition to FLUSH occur on the same beat.
- out_idx never wraps: the maximum is cfg_num_out-1 ≤ 2^PE_BUF_ADDR_WIDTH-1.

Optional Feature:
PE_CTRL_ABORT_EN:
- Defined: adds input abort (1 bit).
- abort=1 in ACCUM or FLUSH -> IDLE on the next edge. ctrl=0 from that edge onward, no flush is issued, done is not pulsed, and config is discarded.
- abort in IDLE or DONE has no effect.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset while in ACCUM (acc_len=4, after 2 beats) -> ctrl, busy, and done go to 0 immediately, with no clock edge required; state=IDLE.
- start with acc_len=3, num_out=2, op_code=3'b101, accumulate=0, data_valid held high -> enable=1 for 3 cycles, then flush with write_req and buf_wr_addr=0; repeat with buf_wr_addr=1; done pulses once; busy low the cycle after.
- Same config with accumulate=1 -> read_req=1 with buf_rd_addr=0 on the first beat of output 0, and with buf_rd_addr=1 on the first beat of output 1; read_req=0 on all other beats.
- acc_len=4, data_valid pattern 1,0,0,1,1,0,1 -> exactly 4 enable cycles, each one cycle after a valid beat; flush follows the 4th.
- acc_len=0 or num_out=0 -> done one cycle after start; no enable, flush, or write_req ever asserted.
- start pulsed mid-tile and during DONE -> ignored; the tile completes with the original config; a new start in IDLE is accepted. With PE_CTRL_ABORT_EN: abort in the 2nd ACCUM beat -> IDLE, no flush, no done.

Source files
------------

// File: rtl/pe_ctrl_sequencer.sv
// Per-PE control sequencer: accumulation beats, optional partial-sum read-back, then flush/write-back per output.
// Optional feature: define PE_CTRL_ABORT_EN to add an abort input that returns ACCUM/FLUSH to IDLE.
module pe_ctrl_sequencer #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int OP_CODE_WIDTH     = 3,
    parameter int CNT_WIDTH         = 16,
    localparam int CTRL_WIDTH       = 8 + 2 * PE_BUF_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         cfg_acc_len,
    input  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_num_out,
    input  logic [OP_CODE_WIDTH-1:0]     cfg_op_code,
    input  logic                         cfg_accumulate,
    input  logic                         data_valid,
`ifdef PE_CTRL_ABORT_EN
    input  logic                         abort,
`endif
    output logic [CTRL_WIDTH-1:0]        ctrl,
    output logic                         busy,
    output logic                         done
);

    typedef struct packed {
        logic [PE_BUF_ADDR_WIDTH-1:0] buf_rd_addr;
        logic [PE_BUF_ADDR_WIDTH-1:0] buf_wr_addr;
        logic                         flush;
        logic                         write_valid;
        logic                         write_req;
        logic                         read_req;
        logic                         enable;
        logic [OP_CODE_WIDTH-1:0]     op_code;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0]         CNT_ONE  = 1;
    localparam logic [PE_BUF_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                       state;
    ctrl_t                        ctrl_q;
    logic [CNT_WIDTH-1:0]         acc_cnt;
    logic [PE_BUF_ADDR_WIDTH-1:0] out_idx;
    logic [CNT_WIDTH-1:0]         acc_len_q;
    logic [PE_BUF_ADDR_WIDTH-1:0] num_out_q;
    logic [OP_CODE_WIDTH-1:0]     op_code_q;
    logic                         accumulate_q;
    logic                         abort_hit;

`ifdef PE_CTRL_ABORT_EN
    assign abort_hit = abort && (state == ACCUM || state == FLUSH);
`else
    assign abort_hit = 1'b0;
`endif

    assign ctrl = ctrl_q;

    // ctrl/busy/done are registered together with the state they describe,
    // so the control word lags the input that caused it by exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ctrl_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            acc_cnt      <= '0;
            out_idx      <= '0;
            acc_len_q    <= '0;
            num_out_q    <= '0;
            op_code_q    <= '0;
            accumulate_q <= 1'b0;
        end else if (abort_hit) begin
            state        <= IDLE;
            ctrl_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            acc_cnt      <= '0;
            out_idx      <= '0;
            acc_len_q    <= '0;
            num_out_q    <= '0;
            op_code_q    <= '0;
            accumulate_q <= 1'b0;
        end else begin
            ctrl_q <= '0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_len_q    <= cfg_acc_len;
                        num_out_q    <= cfg_num_out;
                        op_code_q    <= cfg_op_code;
                        accumulate_q <= cfg_accumulate;
                        acc_cnt      <= '0;
                        out_idx      <= '0;
                        busy         <= 1'b1;
                        if (cfg_acc_len == '0 || cfg_num_out == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    ctrl_q.op_code <= op_code_q;
                    if (data_valid) begin
                        ctrl_q.enable <= 1'b1;
                        // Prior partial sum is fetched alongside the first beat of each output.
                        if (acc_cnt == '0 && accumulate_q) begin
                            ctrl_q.read_req    <= 1'b1;
                            ctrl_q.buf_rd_addr <= out_idx;
                        end
                        if (acc_cnt == acc_len_q - CNT_ONE) begin
                            acc_cnt <= '0;
                            state   <= FLUSH;
                        end else begin
                            acc_cnt <= acc_cnt + CNT_ONE;
                        end
                    end
                end
                FLUSH: begin
                    ctrl_q.flush       <= 1'b1;
                    ctrl_q.write_valid <= 1'b1;
                    ctrl_q.write_req   <= 1'b1;
                    ctrl_q.buf_wr_addr <= out_idx;
                    if (out_idx == num_out_q - ADDR_ONE) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        out_idx <= out_idx + ADDR_ONE;
                        state   <= ACCUM;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Self-checking bench for pe_ctrl_sequencer: vector table, directed corner cases, random vs. phase-queue model.
module tb_pe_ctrl_sequencer;

    localparam int A   = 10;
    localparam int CW  = 16;
    localparam int CTW = 8 + 2 * A;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [CW-1:0]  cfg_acc_len;
    logic [A-1:0]   cfg_num_out;
    logic [2:0]     cfg_op_code;
    logic           cfg_accumulate;
    logic           data_valid;
`ifdef PE_CTRL_ABORT_EN
    logic           abort;
`endif
    logic [CTW-1:0] ctrl;
    logic           busy;
    logic           done;

    pe_ctrl_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_acc_len    (cfg_acc_len),
        .cfg_num_out    (cfg_num_out),
        .cfg_op_code    (cfg_op_code),
        .cfg_accumulate (cfg_accumulate),
        .data_valid     (data_valid),
`ifdef PE_CTRL_ABORT_EN
        .abort          (abort),
`endif
        .ctrl           (ctrl),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [CTW-1:0] mk(input int rda, input int wra, input bit fl, input bit wv,
                                          input bit wr, input bit rd, input bit en, input int op);
        logic [CTW-1:0] c;
        c = {A'(rda), A'(wra), fl, wv, wr, rd, en, 3'(op)};
        return c;
    endfunction

    task automatic chk(input string name, input logic [CTW-1:0] ec, input logic eb, input logic ed);
        n_chk++;
        if (ctrl === ec && busy === eb && done === ed) n_pass++;
        else $display("FAIL %s: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                      name, ctrl, busy, done, ec, eb, ed);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a tile is expanded into a queue of phases; the head is the current phase.
    typedef struct {
        int kind;   // 0 = beat, 1 = flush, 2 = done
        int o;
        int j;
    } item_t;

    item_t          q[$];
    int             m_op;
    bit             m_acc;
    logic [CTW-1:0] exp_c;
    logic           exp_b;
    logic           exp_d;

    task automatic model_step(input logic st, input logic dv, input logic ab,
                              input int al, input int no, input int op, input logic ac);
        exp_c = '0;
        if (q.size() == 0) begin
            if (st) begin
                m_op  = op;
                m_acc = ac;
                if (al != 0 && no != 0)
                    for (int o = 0; o < no; o++) begin
                        for (int j = 0; j < al; j++) q.push_back('{0, o, j});
                        q.push_back('{1, o, 0});
                    end
                q.push_back('{2, 0, 0});
            end
        end else if (ab && q[0].kind != 2) begin
            q.delete();
        end else begin
            case (q[0].kind)
                0: begin
                    if (dv) begin
                        if (q[0].j == 0 && m_acc) exp_c = mk(q[0].o, 0, 0, 0, 0, 1, 1, m_op);
                        else                      exp_c = mk(0, 0, 0, 0, 0, 0, 1, m_op);
                        void'(q.pop_front());
                    end else begin
                        exp_c = mk(0, 0, 0, 0, 0, 0, 0, m_op);
                    end
                end
                1: begin
                    exp_c = mk(0, q[0].o, 1, 1, 1, 0, 0, 0);
                    void'(q.pop_front());
                end
                default: void'(q.pop_front());
            endcase
        end
        exp_b = (q.size() != 0);
        exp_d = exp_b && q[0].kind == 2;
    endtask

    task automatic cyc(input logic st, input logic dv, input logic ab, input int al, input int no,
                       input int op, input logic ac, input string name);
        logic ab_eff;
        start          = st;
        data_valid     = dv;
        cfg_acc_len    = CW'(al);
        cfg_num_out    = A'(no);
        cfg_op_code    = 3'(op);
        cfg_accumulate = ac;
`ifdef PE_CTRL_ABORT_EN
        abort  = ab;
        ab_eff = ab;
`else
        ab_eff = 1'b0;
`endif
        model_step(st, dv, ab_eff, al, no, op, ac);
        tick();
        chk(name, exp_c, exp_b, exp_d);
    endtask

    typedef struct {
        logic           st;
        logic           dv;
        logic [CTW-1:0] c;
        logic           b;
        logic           d;
    } vec_t;

    vec_t tbl[12];
    int   pat[7];
    int   en_cnt;

    initial begin
        // acc_len=3, num_out=2, op=5, accumulate=1, with a stall and two ignored starts
        tbl[0]  = '{1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 1, 1, 5), 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 5), 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 5), 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, mk(0, 0, 1, 1, 1, 0, 0, 0), 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 1, 1, 5), 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 5), 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 5), 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 5), 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, mk(0, 1, 1, 1, 1, 0, 0, 0), 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0};
        pat = '{1, 0, 0, 1, 1, 0, 1};

        reset = 1'b0; start = 1'b0; data_valid = 1'b0;
        cfg_acc_len = '0; cfg_num_out = '0; cfg_op_code = '0; cfg_accumulate = 1'b0;
`ifdef PE_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("reset_state", '0, 1'b0, 1'b0);
        reset = 1'b1;

        // vector table; cfg is valid only on the accepting start, junk afterwards
        for (int i = 0; i < 12; i++) begin
            start      = tbl[i].st;
            data_valid = tbl[i].dv;
            if (i == 0) begin
                cfg_acc_len = 16'd3; cfg_num_out = 10'd2; cfg_op_code = 3'd5; cfg_accumulate = 1'b1;
            end else begin
                cfg_acc_len    = CW'($urandom_range(1, 9));
                cfg_num_out    = A'($urandom_range(1, 9));
                cfg_op_code    = 3'($urandom);
                cfg_accumulate = 1'($urandom);
            end
            tick();
            chk($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d);
        end

        // zero-length tiles finish immediately
        start = 1'b1; cfg_acc_len = 16'd0; cfg_num_out = 10'd2; data_valid = 1'b1;
        tick(); chk("len0_done", '0, 1'b1, 1'b1);
        start = 1'b0;
        tick(); chk("len0_idle", '0, 1'b0, 1'b0);
        start = 1'b1; cfg_acc_len = 16'd3; cfg_num_out = 10'd0;
        tick(); chk("num0_done", '0, 1'b1, 1'b1);
        start = 1'b0;
        tick(); chk("num0_idle", '0, 1'b0, 1'b0);
        data_valid = 1'b0;

        // asynchronous reset in the middle of accumulation
        start = 1'b1; cfg_acc_len = 16'd4; cfg_num_out = 10'd1; cfg_op_code = 3'd2; cfg_accumulate = 1'b0;
        tick(); chk("rst_start", '0, 1'b1, 1'b0);
        start = 1'b0; data_valid = 1'b1;
        tick(); chk("rst_beat1", mk(0, 0, 0, 0, 0, 0, 1, 2), 1'b1, 1'b0);
        tick(); chk("rst_beat2", mk(0, 0, 0, 0, 0, 0, 1, 2), 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 chk("async_reset", '0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        tick(); chk("post_reset_idle", '0, 1'b0, 1'b0);
        data_valid = 1'b0;
        q.delete();

        // stalled beats: acc_len=4 with pattern 1,0,0,1,1,0,1
        en_cnt = 0;
        cyc(1, 0, 0, 4, 1, 6, 1, "stall_start");
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1'(pat[i]), 0, 7, 3, 1, 0, "stall_beat");
            en_cnt += int'(ctrl[3]);
        end
        cyc(0, 0, 0, 7, 3, 1, 0, "stall_flush");
        en_cnt += int'(ctrl[3]);
        cyc(0, 0, 0, 7, 3, 1, 0, "stall_idle");
        n_chk++;
        if (en_cnt == 4) n_pass++;
        else $display("FAIL stall_enable_count: got %0d enable cycles, want 4", en_cnt);

`ifdef PE_CTRL_ABORT_EN
        cyc(1, 0, 0, 3, 2, 1, 0, "abort_start");
        cyc(0, 1, 0, 3, 2, 1, 0, "abort_beat1");
        cyc(0, 1, 1, 3, 2, 1, 0, "abort_beat2");
        chk("abort_cleared", '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 3, 2, 1, 0, "abort_after");
`endif

        for (int i = 0; i < 800; i++)
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 24) == 0),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)), 1'($urandom), "rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
